// File: rtl/pc_pkg.sv
// Shared next-PC select encodings and default vectors for the program-counter unit.
package pc_pkg;

    typedef logic [2:0] next_sel_t;

    localparam next_sel_t SEL_SEQ = 3'd0;
    localparam next_sel_t SEL_BEQ = 3'd1;
    localparam next_sel_t SEL_BNE = 3'd2;
    localparam next_sel_t SEL_JAL = 3'd3;
    localparam next_sel_t SEL_JR  = 3'd4;
    localparam next_sel_t SEL_RET = 3'd5;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with saturating count and sticky overflow flag.
// Push/pop take effect on the next edge; top entry is read combinationally.
module pc_ras #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_data,
    output logic [ADDR_W-1:0] o_top_data,
    output logic              o_empty,
    output logic              o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_top;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic [PTR_W-1:0]  w_top_inc;

    assign w_top_inc  = r_top + PTR_W'(1);
    assign o_top_data = r_mem[r_top];
    assign o_empty    = (r_count == '0);
    assign o_overflow = r_overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_top      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_push) begin
            // When full, the slot above top holds the oldest entry and is simply reused.
            r_top <= w_top_inc;
            if (r_count == CNT_FULL) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_top   <= r_top - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (i_push && !reset) begin
            r_mem[w_top_inc] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC with next-PC mux, trap/eret handling, saved EPC and call/return stack.
// pc updates one edge after its select inputs; stall holds pc, RAS and misalign.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC),
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        next_sel,
    input  logic              zero,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              trap,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_4,
    output logic [ADDR_W-1:0] branch_base_addr,
    output logic [ADDR_W-1:0] epc,
    output logic              ras_empty,
    output logic              ras_overflow,
    output logic              misalign
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_epc;
    logic              r_misalign;

    logic [ADDR_W-1:0] w_pc_plus_4;
    logic [ADDR_W-1:0] w_raw_target;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_taken;
    logic              w_push;
    logic              w_pop;
    logic              w_advance;
    logic              w_ras_empty;
    logic              w_ras_overflow;
    next_sel_t         w_sel;

    assign w_sel       = next_sel_t'(next_sel);
    assign w_pc_plus_4 = r_pc + ADDR_W'(4);
    assign w_advance   = !trap && !eret && !stall;

    always_comb begin
        w_taken      = 1'b0;
        w_raw_target = '0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        case (w_sel)
            SEL_BEQ: begin
                w_taken      = zero;
                w_raw_target = branch_target;
            end
            SEL_BNE: begin
                w_taken      = !zero;
                w_raw_target = branch_target;
            end
            SEL_JAL: begin
                w_taken      = 1'b1;
                w_raw_target = branch_target;
                w_push       = 1'b1;
            end
            SEL_JR: begin
                w_taken      = 1'b1;
                w_raw_target = jump_target;
            end
            SEL_RET: begin
                // An empty stack falls back to the register value instead of predicting.
                w_taken      = 1'b1;
                w_raw_target = w_ras_empty ? jump_target : w_ras_top;
                w_pop        = !w_ras_empty;
            end
            default: begin
                w_taken = 1'b0;
            end
        endcase
    end

    assign w_next_pc = w_taken ? {w_raw_target[ADDR_W-1:2], 2'b00} : w_pc_plus_4;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_misalign <= 1'b0;
        end else if (trap) begin
            r_pc  <= TRAP_VEC;
            r_epc <= r_pc;
        end else if (eret) begin
            r_pc <= r_epc;
        end else if (!stall) begin
            r_pc       <= w_next_pc;
            r_misalign <= w_taken && (w_raw_target[1:0] != 2'b00);
        end
    end

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push && w_advance),
        .i_pop       (w_pop && w_advance),
        .i_push_data (w_pc_plus_4),
        .o_top_data  (w_ras_top),
        .o_empty     (w_ras_empty),
        .o_overflow  (w_ras_overflow)
    );

    assign pc               = r_pc;
    assign pc_plus_4        = w_pc_plus_4;
    assign branch_base_addr = r_pc;
    assign epc              = r_epc;
    assign ras_empty        = w_ras_empty;
    assign ras_overflow     = w_ras_overflow;
    assign misalign         = r_misalign;

endmodule
